// File: rtl/miner_pkg.sv
// ---------------------------------------------------------------------------
// miner_pkg
// Purpose : shared types, widths and helpers for the nonce dispatcher.
// Contents: BLOCK_W/HASH_W/NONCE_W widths, state_t FSM encoding,
//           status_t result codes, result_t packed payload, helpers.
// ---------------------------------------------------------------------------
package miner_pkg;

    localparam int unsigned BLOCK_W = 608;
    localparam int unsigned HASH_W  = 256;
    localparam int unsigned NONCE_W = 32;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        LAUNCH = 2'd1,
        WAIT   = 2'd2,
        REPORT = 2'd3
    } state_t;

    typedef enum logic [1:0] {
        FOUND     = 2'd0,
        EXHAUSTED = 2'd1,
        ABORTED   = 2'd2,
        TIMEOUT   = 2'd3
    } status_t;

    typedef struct packed {
        status_t            status;
        logic [NONCE_W-1:0] nonce;
        logic [HASH_W-1:0]  hash;
    } result_t;

    // Assemble a result payload.
    function automatic result_t make_result(input status_t            st,
                                            input logic [NONCE_W-1:0] n,
                                            input logic [HASH_W-1:0]  h);
        result_t r;
        r.status = st;
        r.nonce  = n;
        r.hash   = h;
        return r;
    endfunction

    // Increment that sticks at all ones.
    function automatic logic [NONCE_W-1:0] sat_inc(input logic [NONCE_W-1:0] v);
        return (v == '1) ? v : v + NONCE_W'(1);
    endfunction

endpackage

// File: rtl/miner_nonce_counter.sv
// ---------------------------------------------------------------------------
// miner_nonce_counter
// Purpose : holds the current batch base nonce and the inclusive end nonce,
//           steps the base by NUM_CORES and flags the last batch.
// Ports   : i_clk, i_rst        clock, async active-high reset
//           i_load              capture i_start/i_end (job accept)
//           i_step              advance base nonce by NUM_CORES
//           i_start, i_end      job range (inclusive)
//           o_nonce, o_end      registered base and end
//           o_last_batch_c      (end - base) < NUM_CORES, 33-bit
//           o_range_empty_c     i_start > i_end (evaluated on load inputs)
// ---------------------------------------------------------------------------
module miner_nonce_counter
    import miner_pkg::*;
#(
    parameter int unsigned NUM_CORES = 10
) (
    input  logic               i_clk,
    input  logic               i_rst,
    input  logic               i_load,
    input  logic               i_step,
    input  logic [NONCE_W-1:0] i_start,
    input  logic [NONCE_W-1:0] i_end,
    output logic [NONCE_W-1:0] o_nonce,
    output logic [NONCE_W-1:0] o_end,
    output logic               o_last_batch_c,
    output logic               o_range_empty_c
);

    logic [NONCE_W-1:0] r_nonce;
    logic [NONCE_W-1:0] r_end;
    logic [NONCE_W:0]   w_remain;

    // Remaining span in 33 bits so the compare is valid up to end = all ones.
    assign w_remain        = {1'b0, r_end} - {1'b0, r_nonce};
    assign o_last_batch_c  = (w_remain < (NONCE_W + 1)'(NUM_CORES));
    assign o_range_empty_c = (i_start > i_end);
    assign o_nonce         = r_nonce;
    assign o_end           = r_end;

    // Base/end registers; a step is only requested when another full batch
    // fits below end, so the base never wraps.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_nonce <= '0;
            r_end   <= '0;
        end else if (i_load) begin
            r_nonce <= i_start;
            r_end   <= i_end;
        end else if (i_step) begin
            r_nonce <= r_nonce + NONCE_W'(NUM_CORES);
        end
    end

endmodule

// File: rtl/miner_nonce_dispatcher.sv
// ---------------------------------------------------------------------------
// miner_nonce_dispatcher
// Purpose : accepts one hashing job and sweeps its nonce range in batches of
//           NUM_CORES, pulsing o_hash_enable per batch and reporting the
//           first in-range winner, exhaustion, abort or (optional) timeout.
// Config  : `define MINER_DISPATCH_TIMEOUT_EN enables the per-batch watchdog
//           (TIMEOUT_CYC cycles from launch); undefined = wait indefinitely.
// Ports   : i_clk, i_rst                   clock, async active-high reset
//           i_job_valid/o_job_ready        job handshake (ready only in IDLE)
//           i_job_block/target/start/end   job payload
//           i_abort                        cancel job in LAUNCH/WAIT
//           o_hash_enable                  one-cycle batch launch
//           o_nonce/o_block/o_target       batch payload to hashing stage
//           i_hash_finished/found/value/nonce  batch completion
//           o_result_valid/i_result_ready  result handshake
//           o_result_status/nonce/hash     result payload
//           o_batch_count                  batches launched (saturating)
// ---------------------------------------------------------------------------
module miner_nonce_dispatcher
    import miner_pkg::*;
#(
    parameter int unsigned NUM_CORES   = 10,
    parameter int unsigned TIMEOUT_CYC = 4096
) (
    input  logic               i_clk,
    input  logic               i_rst,
    input  logic               i_job_valid,
    output logic               o_job_ready,
    input  logic [BLOCK_W-1:0] i_job_block,
    input  logic [HASH_W-1:0]  i_job_target,
    input  logic [NONCE_W-1:0] i_job_start_nonce,
    input  logic [NONCE_W-1:0] i_job_end_nonce,
    input  logic               i_abort,
    output logic               o_hash_enable,
    output logic [NONCE_W-1:0] o_nonce,
    output logic [BLOCK_W-1:0] o_block,
    output logic [HASH_W-1:0]  o_target,
    input  logic               i_hash_finished,
    input  logic               i_hash_found,
    input  logic [HASH_W-1:0]  i_hash_value,
    input  logic [NONCE_W-1:0] i_hash_nonce,
    output logic               o_result_valid,
    input  logic               i_result_ready,
    output logic [1:0]         o_result_status,
    output logic [NONCE_W-1:0] o_result_nonce,
    output logic [HASH_W-1:0]  o_result_hash,
    output logic [NONCE_W-1:0] o_batch_count
);

    if (NUM_CORES == 0) begin : g_bad_num_cores
        $error("NUM_CORES must be at least 1");
    end
    if (TIMEOUT_CYC == 0) begin : g_bad_timeout
        $error("TIMEOUT_CYC must be at least 1");
    end

    state_t             r_state;
    logic               r_job_ready;
    logic               r_hash_enable;
    logic               r_result_valid;
    logic [BLOCK_W-1:0] r_block;
    logic [HASH_W-1:0]  r_target;
    result_t            r_result;
    logic [NONCE_W-1:0] r_batch_count;

    logic [NONCE_W-1:0] w_end;
    logic               w_accept;
    logic               w_step;
    logic               w_last_batch;
    logic               w_range_empty;
    logic               w_found_ok;
    logic               w_wd_expired;

    assign w_accept   = (r_state == IDLE) && i_job_valid && r_job_ready;
    // A winner past end comes from the overshoot of the last batch.
    assign w_found_ok = i_hash_finished && i_hash_found && (i_hash_nonce <= w_end);
    // Same priority as the WAIT branch below: abort, found, then step.
    assign w_step     = (r_state == WAIT) && !i_abort && i_hash_finished
                        && !w_found_ok && !w_last_batch;

    miner_nonce_counter #(
        .NUM_CORES (NUM_CORES)
    ) u_counter (
        .i_clk           (i_clk),
        .i_rst           (i_rst),
        .i_load          (w_accept),
        .i_step          (w_step),
        .i_start         (i_job_start_nonce),
        .i_end           (i_job_end_nonce),
        .o_nonce         (o_nonce),
        .o_end           (w_end),
        .o_last_batch_c  (w_last_batch),
        .o_range_empty_c (w_range_empty)
    );

`ifdef MINER_DISPATCH_TIMEOUT_EN
    localparam int unsigned WD_W = $clog2(TIMEOUT_CYC + 1);
    logic [WD_W-1:0] r_wd_cnt;

    // Cycles elapsed since the current batch's launch cycle.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_wd_cnt <= '0;
        end else if (r_state == LAUNCH) begin
            r_wd_cnt <= WD_W'(1);
        end else if (r_state == WAIT) begin
            r_wd_cnt <= r_wd_cnt + WD_W'(1);
        end
    end

    assign w_wd_expired = (r_state == WAIT) && (r_wd_cnt >= WD_W'(TIMEOUT_CYC - 1));
`else
    assign w_wd_expired = 1'b0;
`endif

    // Control FSM; o_hash_enable is set on entry to LAUNCH so it is high
    // exactly during the LAUNCH cycle.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_state        <= IDLE;
            r_job_ready    <= 1'b1;
            r_hash_enable  <= 1'b0;
            r_result_valid <= 1'b0;
            r_block        <= '0;
            r_target       <= '0;
            r_batch_count  <= '0;
            r_result       <= make_result(FOUND, '0, '1);
        end else begin
            r_hash_enable <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (w_accept) begin
                        r_block       <= i_job_block;
                        r_target      <= i_job_target;
                        r_job_ready   <= 1'b0;
                        if (w_range_empty) begin
                            r_batch_count  <= '0;
                            r_result       <= make_result(EXHAUSTED, '0, '1);
                            r_result_valid <= 1'b1;
                            r_state        <= REPORT;
                        end else begin
                            r_batch_count <= NONCE_W'(1);
                            r_hash_enable <= 1'b1;
                            r_state       <= LAUNCH;
                        end
                    end
                end
                LAUNCH: begin
                    if (i_abort) begin
                        r_result       <= make_result(ABORTED, '0, '1);
                        r_result_valid <= 1'b1;
                        r_state        <= REPORT;
                    end else begin
                        r_state <= WAIT;
                    end
                end
                WAIT: begin
                    if (i_abort) begin
                        r_result       <= make_result(ABORTED, '0, '1);
                        r_result_valid <= 1'b1;
                        r_state        <= REPORT;
                    end else if (w_found_ok) begin
                        r_result       <= make_result(FOUND, i_hash_nonce, i_hash_value);
                        r_result_valid <= 1'b1;
                        r_state        <= REPORT;
                    end else if (i_hash_finished) begin
                        if (w_last_batch) begin
                            r_result       <= make_result(EXHAUSTED, '0, '1);
                            r_result_valid <= 1'b1;
                            r_state        <= REPORT;
                        end else begin
                            r_batch_count <= sat_inc(r_batch_count);
                            r_hash_enable <= 1'b1;
                            r_state       <= LAUNCH;
                        end
                    end else if (w_wd_expired) begin
                        r_result       <= make_result(TIMEOUT, '0, '1);
                        r_result_valid <= 1'b1;
                        r_state        <= REPORT;
                    end
                end
                REPORT: begin
                    if (i_result_ready) begin
                        r_result_valid <= 1'b0;
                        r_job_ready    <= 1'b1;
                        r_state        <= IDLE;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign o_job_ready     = r_job_ready;
    assign o_hash_enable   = r_hash_enable;
    assign o_block         = r_block;
    assign o_target        = r_target;
    assign o_result_valid  = r_result_valid;
    assign o_result_status = r_result.status;
    assign o_result_nonce  = r_result.nonce;
    assign o_result_hash   = r_result.hash;
    assign o_batch_count   = r_batch_count;

endmodule
